// File: rtl/proiect_pkg.sv
// Shared datapath constants and types for the proiect register file.
// REGFILE_WB_BYPASS_EN selects the write-to-read bypass on the read ports.
package proiect_pkg;

    localparam int REG_WIDTH = 32;
    localparam int REG_COUNT = 32;
    localparam int REG_ZERO  = 0;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] word_t;

`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: zero-index mask, reset mask and the
// write-to-read bypass (enabled by REGFILE_WB_BYPASS_EN via proiect_pkg).
module regfile_rd_port
    import proiect_pkg::*;
#(
    parameter int WIDTH  = REG_WIDTH,
    parameter int ADDR_W = 5
) (
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [WIDTH-1:0]  stored,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    always_comb begin
        rdata = '0;
        if (!rst && raddr != ZERO_IDX) begin
            rdata = stored;
            // Pending write wins over the stored copy when the bypass is built in.
            if (BYPASS_EN && we && waddr == raddr) begin
                rdata = wdata;
            end
        end
    end

endmodule

// File: rtl/regfile_wb.sv
// Writeback register file: DEPTH x WIDTH, r0 reads as zero, two combinational
// read ports. Optional bypass controlled by REGFILE_WB_BYPASS_EN.
module regfile_wb
    import proiect_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH,
    parameter int DEPTH = REG_COUNT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr1,
    input  logic [$clog2(DEPTH)-1:0] raddr2,
    output logic [WIDTH-1:0]         rdata1,
    output logic [WIDTH-1:0]         rdata2
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Entry 0 exists in the array but is never written, so it stays at zero.
    always_comb begin
        mem_d = mem_q;
        if (we && waddr != ZERO_IDX) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    regfile_rd_port #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_rd_port1 (
        .rst    (rst),
        .raddr  (raddr1),
        .stored (mem_q[raddr1]),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .rdata  (rdata1)
    );

    regfile_rd_port #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_rd_port2 (
        .rst    (rst),
        .raddr  (raddr2),
        .stored (mem_q[raddr2]),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .rdata  (rdata2)
    );

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb with an array reference model checked every negedge.
`timescale 1ns/1ps
module tb_regfile_wb;
    import proiect_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      we;
    reg_addr_t waddr;
    word_t     wdata;
    reg_addr_t raddr1;
    reg_addr_t raddr2;
    word_t     rdata1;
    word_t     rdata2;

    int checks = 0;
    int errors = 0;

    word_t model [32];

`ifdef REGFILE_WB_BYPASS_EN
    localparam bit TB_BYPASS = 1'b1;
`else
    localparam bit TB_BYPASS = 1'b0;
`endif

    regfile_wb dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: what the architecture says a read must return.
    function automatic word_t exp_rd(input reg_addr_t a);
        if (rst) return '0;
        if (a == 0) return '0;
        if (TB_BYPASS && we && waddr == a) return wdata;
        return model[a];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else if (we && waddr != 0) begin
            model[waddr] = wdata;
        end
    end

    always @(negedge clk) begin
        check("model_rd1", rdata1, exp_rd(raddr1));
        check("model_rd2", rdata2, exp_rd(raddr2));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
        repeat (2) tick();
        rst = 1'b0;

        // Preload r1..r31 with all ones
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; waddr = reg_addr_t'(i); wdata = 32'hFFFF_FFFF;
            tick();
        end
        we = 1'b0;
        raddr1 = 5'd31; raddr2 = 5'd1;
        #1;
        check("preload_r31", rdata1, 32'hFFFF_FFFF);
        check("preload_r1", rdata2, 32'hFFFF_FFFF);

        // Asynchronous reset between edges, then sweep while held
        rst = 1'b1;
        #1;
        check("rst_async_rd1", rdata1, 32'h0);
        for (int a = 0; a < 32; a++) begin
            raddr1 = reg_addr_t'(a); raddr2 = reg_addr_t'(31 - a);
            #1;
            check("rst_sweep_rd1", rdata1, 32'h0);
            check("rst_sweep_rd2", rdata2, 32'h0);
            tick();
        end
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            raddr1 = reg_addr_t'(a); raddr2 = reg_addr_t'(31 - a);
            #1;
            check("post_rst_rd1", rdata1, 32'h0);
            check("post_rst_rd2", rdata2, 32'h0);
            tick();
        end

        // Basic write/read, first write right after reset release
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
        tick();
        waddr = 5'd17; wdata = 32'h1234_5678;
        tick();
        we = 1'b0;
        raddr1 = 5'd5; raddr2 = 5'd17;
        #1;
        check("basic_r5", rdata1, 32'hDEAD_BEEF);
        check("basic_r17", rdata2, 32'h1234_5678);
        raddr1 = 5'd17; raddr2 = 5'd17;
        #1;
        check("same_entry_p1", rdata1, 32'h1234_5678);
        check("same_entry_p2", rdata2, 32'h1234_5678);

        // Zero register
        tick();
        we = 1'b1; waddr = 5'd0; wdata = 32'hA5A5_A5A5; raddr1 = 5'd0; raddr2 = 5'd0;
        #1;
        check("r0_same_p1", rdata1, 32'h0);
        check("r0_same_p2", rdata2, 32'h0);
        tick();
        we = 1'b0;
        #1;
        check("r0_next_p1", rdata1, 32'h0);
        check("r0_next_p2", rdata2, 32'h0);

        // Same-cycle read-after-write on r9
        tick();
        we = 1'b1; waddr = 5'd9; wdata = 32'h1;
        tick();
        wdata = 32'h2; raddr1 = 5'd9; raddr2 = 5'd9;
        #1;
        check("raw_before_p1", rdata1, TB_BYPASS ? 32'h2 : 32'h1);
        check("raw_before_p2", rdata2, TB_BYPASS ? 32'h2 : 32'h1);
        tick();
        we = 1'b0;
        #1;
        check("raw_after_p1", rdata1, 32'h2);
        check("raw_after_p2", rdata2, 32'h2);

        // Write disable holds r3
        tick();
        we = 1'b1; waddr = 5'd3; wdata = 32'h55;
        tick();
        we = 1'b0; wdata = 32'hAA; raddr1 = 5'd3; raddr2 = 5'd9;
        repeat (4) tick();
        #1;
        check("we0_r3", rdata1, 32'h55);
        check("we0_r9", rdata2, 32'h2);

        // Reset mid-operation with a pending write to r12
        we = 1'b1; waddr = 5'd12; wdata = 32'h77; raddr1 = 5'd12; raddr2 = 5'd12;
        #1;
        check("mid_pre_p1", rdata1, TB_BYPASS ? 32'h77 : 32'h0);
        rst = 1'b1;
        #1;
        check("mid_rst_p1", rdata1, 32'h0);
        check("mid_rst_p2", rdata2, 32'h0);
        tick();
        rst = 1'b0; we = 1'b0;
        #1;
        check("mid_after_r12_p1", rdata1, 32'h0);
        check("mid_after_r12_p2", rdata2, 32'h0);
        raddr1 = 5'd5; raddr2 = 5'd3;
        #1;
        check("mid_after_r5", rdata1, 32'h0);
        check("mid_after_r3", rdata2, 32'h0);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb.md
# regfile_wb

Register file sitting directly downstream of the writeback select mux in the `proiect` datapath. The 32-bit result chosen by the mux (ALU result vs. memory load data) arrives on `wdata`. It is stored into one of `DEPTH` architectural registers on the clock edge. Two independent read ports feed the decode/operand stage. Register 0 is hardwired to zero. An optional write-to-read bypass removes the one-cycle read-after-write bubble.

## Interface
Parameters:
- `WIDTH`, 32, data width; matches the writeback mux `WIDTH`.
- `DEPTH`, 32, number of registers; must be a power of two, minimum 2.
- `ADDR_W`, `$clog2(DEPTH)`, localparam, address width; not overridable.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `we`  in  1  write enable for the current cycle.
- `waddr`  in  ADDR_W  write register index.
- `wdata`  in  WIDTH  write data (writeback mux `res`).
- `raddr1`  in  ADDR_W  read port 1 index.
- `raddr2`  in  ADDR_W  read port 2 index.
- `rdata1`  out  WIDTH  read port 1 data.
- `rdata2`  out  WIDTH  read port 2 data.

## Operation
- Storage: `DEPTH` entries, each `WIDTH` bits. Entry 0 is not stored, or is stored and never written.
- Write: on a rising `clk` with `rst` low and `we`=1, write `wdata` into entry `waddr`.
- Writes with `waddr`=0 are discarded silently.
- `we`=0 leaves all entries unchanged, whatever the values on `waddr` and `wdata`.
- Read: `rdataN` is combinational from `raddrN`.
- `raddrN`=0 always gives 0.
- Both ports may address the same entry; both then return the same value.
- Bypass (when compiled in, see Configuration): if `we`=1, `waddr`=`raddrN` and `waddr`≠0, then `rdataN`=`wdata` in the same cycle.
- Arithmetic: no arithmetic; addresses are used unsigned. `ADDR_W` covers exactly `DEPTH` entries, so no address is out of range.
- Reset:
  - Asserting `rst` clears every entry to 0 immediately, without waiting for `clk`.
  - While `rst` is high, writes are ignored, bypass is suppressed, and both `rdata1` and `rdata2` are 0.
  - Reset mid-operation: a write presented on the same edge on which `rst` is high is lost.

## Timing
- Write latency: 1 edge.
- Without bypass, data written at edge N is visible on the read ports from just after edge N.
  - A same-cycle read before edge N returns the old value.
- With bypass, a read of `waddr` reflects `wdata` combinationally in the cycle the write is presented.
- Read path is purely combinational, with no registered outputs. The read latency seen by decode is 0 cycles.
- First write after reset: with `rst` deasserted before edge N, a write with `we`=1 at edge N is committed normally.
- No handshake. The upstream stage owns `we`, and every asserted cycle commits.

## Configuration
- Macro: `REGFILE_WB_BYPASS_EN`.
- Defined:
  - Read ports forward `wdata` when a write to the same nonzero index is pending that cycle.
  - Bypass has priority over stored data and is masked by `rst`.
- Undefined:
  - Read ports return stored contents only.
  - The pipeline must then insert a 1-cycle stall on read-after-write hazards.

## Structure
- Shared package `proiect_pkg` holds:
  - `REG_WIDTH`=32 and `REG_COUNT`=32.
  - Typedef `reg_addr_t` (logic [4:0]).
  - Typedef `word_t` (logic [31:0]).
  - Constant `REG_ZERO`=0.
- One natural sub-module, `regfile_rd_port`, instantiated twice.
  - It does the zero-index masking, the optional bypass compare and select, and the reset masking for one read port.
- Storage array and write logic stay in the top.

## Test plan
- Reset: assert `rst` with all entries preloaded to `32'hFFFF_FFFF`, sweep `raddr1`/`raddr2` over 0..31 -> all reads 0. Deassert `rst` -> still 0.
- Basic write/read: write `32'hDEAD_BEEF` to r5 and `32'h1234_5678` to r17 on consecutive edges, then read r5 on port 1 and r17 on port 2 -> `32'hDEAD_BEEF` and `32'h1234_5678`.
- Zero register: `we`=1, `waddr`=0, `wdata`=`32'hA5A5_A5A5`, then read r0 on both ports -> 0.
  - Check the same cycle and the next cycle.
- Same-cycle RAW: r9 holds `32'h1`, present a write of `32'h2` to r9 while reading r9 on both ports.
  - With the bypass macro -> reads `32'h2` before the edge.
  - Without the macro -> `32'h1` before the edge, `32'h2` after it.
- Write disable: r3=`32'h55`, drive `we`=0, `waddr`=3, `wdata`=`32'hAA`, clock 4 edges -> r3 still `32'h55`.
- Reset mid-operation: assert `rst` asynchronously between edges while `we`=1 writes `32'h77` to r12 -> `rdata` drops to 0 at once and r12=0 after `rst` is deasserted.
